// File: rtl/display_scan_controller.sv
// display_scan_controller: 4-digit multiplexed 7-segment scan with frame-boundary arbitration and blanking gaps.
// Optional feature macro: DISPLAY_BLINK_EN (blink alarm-owned frames every BLINK_FRAMES frames).
module display_scan_controller #(
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sns_req,
  input  logic [15:0] sns_data,
  output logic        sns_ack,
  input  logic        alm_req,
  input  logic [15:0] alm_data,
  output logic        alm_ack,
  output logic [3:0]  dig_en,
  output logic [6:0]  seg,
  output logic        frame_start,
  output logic        owner
);

  localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  if (DWELL_CYCLES < 1 || BLANK_CYCLES < 1 || BLINK_FRAMES < 1) begin : g_bad_params
    $error("display_scan_controller: DWELL_CYCLES, BLANK_CYCLES and BLINK_FRAMES must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_ARB,
    ST_BLANK,
    ST_ON
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   frame_q, frame_d;
  logic          owner_q, owner_d;
  logic          sns_ack_q, sns_ack_d;
  logic          alm_ack_q, alm_ack_d;
  logic          frame_start_q, frame_start_d;
  logic [3:0]    dig_en_q, dig_en_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    nib_d;
  logic          dark_d;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    s = '0;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

`ifdef DISPLAY_BLINK_EN
  localparam int unsigned BW = $clog2(2 * BLINK_FRAMES);
  logic [BW-1:0] blink_q, blink_d;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    frame_d       = frame_q;
    owner_d       = owner_q;
    sns_ack_d     = 1'b0;
    alm_ack_d     = 1'b0;
    frame_start_d = 1'b0;
`ifdef DISPLAY_BLINK_EN
    blink_d       = blink_q;
`endif

    case (state_q)
      ST_ARB: begin
        state_d       = ST_BLANK;
        cnt_d         = '0;
        idx_d         = '0;
        frame_start_d = 1'b1;
`ifdef DISPLAY_BLINK_EN
        // Blink phase restarts visible whenever the alarm takes the display over.
        if (alm_req && !owner_q) begin
          blink_d = '0;
        end else if (blink_q == BW'(2 * BLINK_FRAMES - 1)) begin
          blink_d = '0;
        end else begin
          blink_d = blink_q + 1'b1;
        end
`endif
        if (alm_req) begin
          frame_d   = alm_data;
          owner_d   = 1'b1;
          alm_ack_d = 1'b1;
        end else if (sns_req) begin
          frame_d   = sns_data;
          owner_d   = 1'b0;
          sns_ack_d = 1'b1;
        end
      end
      ST_BLANK: begin
        if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ON: begin
        if (cnt_q == CW'(DWELL_CYCLES - 1)) begin
          cnt_d = '0;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = ST_ARB;
          end else begin
            state_d = ST_BLANK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_ARB;
    endcase

`ifdef DISPLAY_BLINK_EN
    dark_d = owner_d && (blink_d >= BW'(BLINK_FRAMES));
`else
    dark_d = 1'b0;
`endif

    // Outputs are decoded from next-state values so the registered pins line up with the state.
    nib_d    = 4'(frame_d >> {idx_d, 2'b00});
    dig_en_d = '0;
    seg_d    = '0;
    if (state_d == ST_ON && !dark_d) begin
      dig_en_d = 4'b0001 << idx_d;
      seg_d    = hex7(nib_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_ARB;
      cnt_q         <= '0;
      idx_q         <= '0;
      frame_q       <= '0;
      owner_q       <= 1'b0;
      sns_ack_q     <= 1'b0;
      alm_ack_q     <= 1'b0;
      frame_start_q <= 1'b0;
      dig_en_q      <= '0;
      seg_q         <= '0;
`ifdef DISPLAY_BLINK_EN
      blink_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      frame_q       <= frame_d;
      owner_q       <= owner_d;
      sns_ack_q     <= sns_ack_d;
      alm_ack_q     <= alm_ack_d;
      frame_start_q <= frame_start_d;
      dig_en_q      <= dig_en_d;
      seg_q         <= seg_d;
`ifdef DISPLAY_BLINK_EN
      blink_q       <= blink_d;
`endif
    end
  end

  assign sns_ack     = sns_ack_q;
  assign alm_ack     = alm_ack_q;
  assign frame_start = frame_start_q;
  assign owner       = owner_q;
  assign dig_en      = dig_en_q;
  assign seg         = seg_q;

endmodule
